// File: rtl/apb_initiator.sv
// ---------------------------------------------------------------------------
// apb_initiator
//
// Purpose:
//   Turns a valid/ready request/response port into single APB transfers.
//   One transfer is outstanding at a time and always walks
//   IDLE -> SETUP -> ACCESS -> RESP. A new request is accepted only in IDLE,
//   so responses come back strictly in request order.
//
// Optional feature (macro APB_INITIATOR_TIMEOUT_EN):
//   When defined, an ACCESS phase that sees pready_i low for TIMEOUT_CYCLES
//   cycles is abandoned. The transfer then completes with rsp_slverr_o = 1
//   and rsp_rdata_o = '0. A pready_i that arrives in the limit cycle still
//   wins. Without the macro ACCESS waits indefinitely.
//
// Ports:
//   pclk_i, preset_ni        clock, asynchronous active-low reset
//   req_valid_i/req_ready_o  request handshake (ready only in IDLE)
//   req_addr_i, req_write_i, req_wdata_i, req_strb_i, req_prot_i
//                            request payload, sampled on acceptance
//   rsp_valid_o/rsp_ready_i  response handshake
//   rsp_rdata_o, rsp_slverr_o
//                            response payload ('0 read data for writes)
//   paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
//                            APB initiator outputs
//   pready_i, prdata_i, pslverr_i
//                            APB completer inputs, used only in ACCESS
// ---------------------------------------------------------------------------
module apb_initiator #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    pclk_i,
  input  logic                    preset_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic                    req_write_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strb_i,
  input  logic [2:0]              req_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_slverr_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [2:0]              pprot_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic                    pready_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pslverr_i
);

  // Parameter sanity checks, evaluated at elaboration.
  if (DATA_WIDTH % 8 != 0) begin : g_chk_data_width
    $error("apb_initiator: DATA_WIDTH must be a multiple of 8");
  end
  if (ADDR_WIDTH < 1) begin : g_chk_addr_width
    $error("apb_initiator: ADDR_WIDTH must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_chk_timeout
    $error("apb_initiator: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic                      w_timeout;
  logic [ADDR_WIDTH-1:0]     r_paddr;
  logic [2:0]                r_pprot;
  logic                      r_pwrite;
  logic [DATA_WIDTH-1:0]     r_pwdata;
  logic [DATA_WIDTH/8-1:0]   r_pstrb;
  logic [DATA_WIDTH-1:0]     r_rdata;
  logic                      r_slverr;

`ifdef APB_INITIATOR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_count;

  // r_count holds the number of wait cycles already seen in this ACCESS, so
  // the current wait cycle is the limit one when r_count == TIMEOUT_CYCLES-1.
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      r_count <= '0;
    end else if (r_state == ST_SETUP) begin
      r_count <= '0;
    end else if (r_state == ST_ACCESS && !pready_i) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign w_timeout = (r_state == ST_ACCESS) && !pready_i &&
                     (r_count == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (req_valid_i) w_next = ST_SETUP;
      ST_SETUP:  w_next = ST_ACCESS;
      ST_ACCESS: if (pready_i || w_timeout) w_next = ST_RESP;
      ST_RESP:   if (rsp_ready_i) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // APB payload is captured once on acceptance and then held, which keeps it
  // stable through wait states and after the transfer. Reads carry no strobes.
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      r_paddr  <= '0;
      r_pprot  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
      r_pstrb  <= '0;
      r_rdata  <= '0;
      r_slverr <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && req_valid_i) begin
        r_paddr  <= req_addr_i;
        r_pprot  <= req_prot_i;
        r_pwrite <= req_write_i;
        r_pwdata <= req_wdata_i;
        r_pstrb  <= req_write_i ? req_strb_i : '0;
      end
      if (r_state == ST_ACCESS) begin
        if (pready_i) begin
          r_rdata  <= r_pwrite ? '0 : prdata_i;
          r_slverr <= pslverr_i;
        end else if (w_timeout) begin
          r_rdata  <= '0;
          r_slverr <= 1'b1;
        end
      end
    end
  end

  assign req_ready_o  = (r_state == ST_IDLE);
  assign psel_o       = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
  assign penable_o    = (r_state == ST_ACCESS);
  assign rsp_valid_o  = (r_state == ST_RESP);
  assign rsp_rdata_o  = r_rdata;
  assign rsp_slverr_o = r_slverr;
  assign paddr_o      = r_paddr;
  assign pprot_o      = r_pprot;
  assign pwrite_o     = r_pwrite;
  assign pwdata_o     = r_pwdata;
  assign pstrb_o      = r_pstrb;

endmodule

// File: tb/tb_apb_initiator.sv
// ---------------------------------------------------------------------------
// tb_apb_initiator
//
// Purpose:
//   Self-checking bench for apb_initiator. A driver task plays the requester,
//   the APB completer and the response consumer for one transfer and records
//   what it observed; each scenario task computes its own expectations from
//   the transfer it asked for and compares inline. Build with
//   APB_INITIATOR_TIMEOUT_EN defined to exercise the timeout path
//   (TIMEOUT_CYCLES = 4 here).
// ---------------------------------------------------------------------------
module tb_apb_initiator;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          pclk = 1'b0;
  logic          preset_ni = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i = '0;
  logic          req_write_i = 1'b0;
  logic [DW-1:0] req_wdata_i = '0;
  logic [SW-1:0] req_strb_i = '0;
  logic [2:0]    req_prot_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_slverr_o;
  logic [AW-1:0] paddr_o;
  logic [2:0]    pprot_o;
  logic          psel_o;
  logic          penable_o;
  logic          pwrite_o;
  logic [DW-1:0] pwdata_o;
  logic [SW-1:0] pstrb_o;
  logic          pready_i = 1'b0;
  logic [DW-1:0] prdata_i = '0;
  logic          pslverr_i = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 pclk = ~pclk;

  apb_initiator #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)
  ) dut (
    .pclk_i(pclk), .preset_ni(preset_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_write_i(req_write_i),
    .req_wdata_i(req_wdata_i), .req_strb_i(req_strb_i), .req_prot_i(req_prot_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_slverr_o(rsp_slverr_o),
    .paddr_o(paddr_o), .pprot_o(pprot_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .pready_i(pready_i), .prdata_i(prdata_i), .pslverr_i(pslverr_i)
  );

  typedef struct {
    logic          setupPsel;
    logic          setupPen;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic [2:0]    pprot;
    logic          pwrite;
    int            accessCycles;
    logic          stable;
    logic          rspPsel;
    int            rspCycles;
    logic [DW-1:0] rdata;
    logic          slverr;
    logic          rspStable;
    logic          busyReady;
    logic          hung;
    logic          readyAfter;
    logic [AW-1:0] holdAddr;
  } obs_t;

  // Outputs are sampled 1 ns after the rising edge; inputs for the next edge
  // are driven in the same window.
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Runs one transfer from the IDLE window. waits = number of ACCESS cycles
  // with pready low before completion; bp = cycles rsp_ready is held low.
  // Request inputs carry garbage with valid high while the DUT is busy.
  task automatic do_txn(input logic [AW-1:0] addr, input logic wr,
                        input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                        input logic [2:0] prot, input int waits,
                        input logic [DW-1:0] rdata, input logic serr,
                        input int bp, output obs_t o);
    int k;
    int j;
    o = '{default: '0};
    o.stable = 1'b1;
    o.rspStable = 1'b1;
    req_valid_i = 1'b1; req_addr_i = addr; req_write_i = wr;
    req_wdata_i = wdata; req_strb_i = strb; req_prot_i = prot;
    rsp_ready_i = 1'b0; pready_i = 1'b0;
    tick();
    o.setupPsel = psel_o; o.setupPen = penable_o;
    o.paddr = paddr_o; o.pwdata = pwdata_o; o.pstrb = pstrb_o;
    o.pprot = pprot_o; o.pwrite = pwrite_o;
    o.busyReady = req_ready_o;
    req_addr_i = $urandom; req_write_i = 1'($urandom); req_wdata_i = $urandom;
    req_strb_i = SW'($urandom); req_prot_i = 3'($urandom);
    pready_i = 1'($urandom); prdata_i = $urandom; pslverr_i = 1'($urandom);
    tick();
    k = 0;
    while (psel_o && penable_o && k < 300) begin
      o.accessCycles++;
      if (paddr_o !== o.paddr || pwdata_o !== o.pwdata || pstrb_o !== o.pstrb ||
          pprot_o !== o.pprot || pwrite_o !== o.pwrite) o.stable = 1'b0;
      o.busyReady |= req_ready_o;
      pready_i  = (k >= waits);
      prdata_i  = (k >= waits) ? rdata : $urandom;
      pslverr_i = (k >= waits) ? serr : 1'($urandom);
      tick();
      k++;
    end
    o.rspPsel = psel_o | penable_o;
    pready_i = 1'($urandom); prdata_i = $urandom; pslverr_i = 1'($urandom);
    j = 0;
    while (rsp_valid_o && j < 300) begin
      if (j == 0) begin
        o.rdata = rsp_rdata_o; o.slverr = rsp_slverr_o;
      end else if (rsp_rdata_o !== o.rdata || rsp_slverr_o !== o.slverr) begin
        o.rspStable = 1'b0;
      end
      o.rspCycles++;
      o.busyReady |= req_ready_o;
      rsp_ready_i = (j >= bp);
      if (rsp_ready_i) req_valid_i = 1'b0;
      tick();
      j++;
    end
    req_valid_i = 1'b0; rsp_ready_i = 1'b0; pready_i = 1'b0;
    o.hung = (k >= 300) || (j >= 300);
    o.readyAfter = req_ready_o;
    o.holdAddr = paddr_o;
  endtask

  task automatic test_reset();
    preset_ni = 1'b0;
    repeat (2) tick();
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready got=%0b exp=1", req_ready_o); end
    checks++; if ({psel_o, penable_o, rsp_valid_o, pwrite_o, rsp_slverr_o} !== 5'b0) begin errors++; $display("[TB] FAIL reset_ctrl got=%b exp=00000", {psel_o, penable_o, rsp_valid_o, pwrite_o, rsp_slverr_o}); end
    checks++; if ({paddr_o, pwdata_o, pstrb_o, pprot_o, rsp_rdata_o} !== '0) begin errors++; $display("[TB] FAIL reset_data got=%h/%h/%h/%h/%h exp=0", paddr_o, pwdata_o, pstrb_o, pprot_o, rsp_rdata_o); end
    #3 preset_ni = 1'b1;
    tick();
    checks++; if (req_ready_o !== 1'b1 || psel_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_release got=%0b%0b exp=10", req_ready_o, psel_o); end
  endtask

  task automatic test_read_zero_wait();
    obs_t o;
    do_txn(32'h0000_1004, 1'b0, 32'h5555_AAAA, 4'hF, 3'h2, 0, 32'hDEAD_BEEF, 1'b0, 0, o);
    checks++; if (o.setupPsel !== 1'b1 || o.setupPen !== 1'b0) begin errors++; $display("[TB] FAIL rd0_setup got=%0b%0b exp=10", o.setupPsel, o.setupPen); end
    checks++; if (o.accessCycles != 1) begin errors++; $display("[TB] FAIL rd0_access_cycles got=%0d exp=1", o.accessCycles); end
    checks++; if (o.rspPsel !== 1'b0 || o.rspCycles != 1) begin errors++; $display("[TB] FAIL rd0_resp got=psel%0b cyc%0d exp=psel0 cyc1", o.rspPsel, o.rspCycles); end
    checks++; if (o.rdata !== 32'hDEAD_BEEF || o.slverr !== 1'b0) begin errors++; $display("[TB] FAIL rd0_rsp got=%h/%0b exp=deadbeef/0", o.rdata, o.slverr); end
    checks++; if (o.pstrb !== 4'h0 || o.paddr !== 32'h0000_1004 || o.pwrite !== 1'b0 || o.pprot !== 3'h2) begin errors++; $display("[TB] FAIL rd0_apb got=%h/%h/%0b/%0h exp=0/00001004/0/2", o.pstrb, o.paddr, o.pwrite, o.pprot); end
    checks++; if (o.readyAfter !== 1'b1 || o.busyReady !== 1'b0) begin errors++; $display("[TB] FAIL rd0_ready got=after%0b busy%0b exp=after1 busy0", o.readyAfter, o.busyReady); end
  endtask

  task automatic test_write_wait();
    obs_t o;
    do_txn(32'h0000_0020, 1'b1, 32'h1234_5678, 4'h3, 3'h5, 3, 32'hFFFF_FFFF, 1'b0, 0, o);
    checks++; if (o.accessCycles != 4 || o.stable !== 1'b1) begin errors++; $display("[TB] FAIL wr3_access got=cyc%0d stable%0b exp=cyc4 stable1", o.accessCycles, o.stable); end
    checks++; if (o.paddr !== 32'h20 || o.pwdata !== 32'h1234_5678 || o.pstrb !== 4'h3 || o.pwrite !== 1'b1) begin errors++; $display("[TB] FAIL wr3_apb got=%h/%h/%h/%0b exp=20/12345678/3/1", o.paddr, o.pwdata, o.pstrb, o.pwrite); end
    checks++; if (o.rdata !== 32'h0 || o.slverr !== 1'b0) begin errors++; $display("[TB] FAIL wr3_rsp got=%h/%0b exp=0/0", o.rdata, o.slverr); end
    checks++; if (o.holdAddr !== 32'h20) begin errors++; $display("[TB] FAIL wr3_hold_addr got=%h exp=20", o.holdAddr); end
  endtask

  task automatic test_error_backpressure();
    obs_t o;
    do_txn(32'h0000_0400, 1'b0, 32'h0, 4'h0, 3'h0, 1, 32'hCAFE_0001, 1'b1, 5, o);
    checks++; if (o.rspCycles != 6 || o.rspStable !== 1'b1) begin errors++; $display("[TB] FAIL err_rsp_hold got=cyc%0d stable%0b exp=cyc6 stable1", o.rspCycles, o.rspStable); end
    checks++; if (o.slverr !== 1'b1 || o.rdata !== 32'hCAFE_0001) begin errors++; $display("[TB] FAIL err_rsp got=%0b/%h exp=1/cafe0001", o.slverr, o.rdata); end
    checks++; if (o.busyReady !== 1'b0 || o.readyAfter !== 1'b1) begin errors++; $display("[TB] FAIL err_ready got=busy%0b after%0b exp=busy0 after1", o.busyReady, o.readyAfter); end
    do_txn(32'h0000_0404, 1'b1, 32'h0BAD_F00D, 4'hC, 3'h1, 0, 32'h0, 1'b0, 0, o);
    checks++; if (o.setupPsel !== 1'b1 || o.paddr !== 32'h404 || o.slverr !== 1'b0) begin errors++; $display("[TB] FAIL err_next_txn got=%0b/%h/%0b exp=1/404/0", o.setupPsel, o.paddr, o.slverr); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [3];
    logic [AW-1:0] seenAddr [$];
    int rise [$];
    int idx;
    logic prevPsel;
    logic accepting;
    addrs[0] = 32'h100; addrs[1] = 32'h204; addrs[2] = 32'h308;
    idx = 0; prevPsel = 1'b0;
    rsp_ready_i = 1'b1; pready_i = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (idx < 3) begin
        req_valid_i = 1'b1; req_addr_i = addrs[idx]; req_write_i = 1'b0;
      end else begin
        req_valid_i = 1'b0;
      end
      prdata_i = $urandom;
      accepting = req_ready_o && req_valid_i;
      tick();
      if (accepting) idx++;
      if (psel_o && !prevPsel) begin
        rise.push_back(c + 1);
        seenAddr.push_back(paddr_o);
      end
      prevPsel = psel_o;
    end
    rsp_ready_i = 1'b0; pready_i = 1'b0; req_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= rise.size() || rise[i] != 1 + 4 * i || seenAddr[i] !== addrs[i]) begin
        errors++;
        $display("[TB] FAIL b2b_psel_rise%0d got=%0d exp=cycle %0d addr %h", i, (i < rise.size()) ? rise[i] : -1, 1 + 4 * i, addrs[i]);
      end
    end
    checks++; if (rise.size() != 3) begin errors++; $display("[TB] FAIL b2b_count got=%0d exp=3", rise.size()); end
  endtask

  task automatic test_reset_mid_access();
    obs_t o;
    req_valid_i = 1'b1; req_addr_i = 32'h7777_0000; req_write_i = 1'b1;
    req_wdata_i = 32'h1111_2222; req_strb_i = 4'hF; pready_i = 1'b0;
    tick();
    req_valid_i = 1'b0;
    repeat (2) tick();
    checks++; if (psel_o !== 1'b1 || penable_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_access got=%0b%0b exp=11", psel_o, penable_o); end
    #2 preset_ni = 1'b0;
    #1;
    checks++; if ({psel_o, penable_o, rsp_valid_o} !== 3'b000) begin errors++; $display("[TB] FAIL rst_async_drop got=%b exp=000", {psel_o, penable_o, rsp_valid_o}); end
    checks++; if (paddr_o !== '0 || pwdata_o !== '0) begin errors++; $display("[TB] FAIL rst_async_data got=%h/%h exp=0/0", paddr_o, pwdata_o); end
    @(negedge pclk);
    preset_ni = 1'b1;
    tick();
    checks++; if (req_ready_o !== 1'b1 || psel_o !== 1'b0 || rsp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_release got=%0b%0b%0b exp=100", req_ready_o, psel_o, rsp_valid_o); end
    do_txn(32'h0000_0800, 1'b0, 32'h0, 4'h0, 3'h0, 0, 32'h0123_4567, 1'b0, 0, o);
    checks++; if (o.rdata !== 32'h0123_4567 || o.accessCycles != 1) begin errors++; $display("[TB] FAIL rst_recover got=%h/%0d exp=01234567/1", o.rdata, o.accessCycles); end
  endtask

`ifdef APB_INITIATOR_TIMEOUT_EN
  task automatic test_timeout();
    obs_t o;
    do_txn(32'h0000_0C00, 1'b0, 32'h0, 4'h0, 3'h0, 1000, 32'h8888_9999, 1'b0, 0, o);
    checks++; if (o.accessCycles != 4 || o.rspPsel !== 1'b0) begin errors++; $display("[TB] FAIL to_access got=cyc%0d psel%0b exp=cyc4 psel0", o.accessCycles, o.rspPsel); end
    checks++; if (o.slverr !== 1'b1 || o.rdata !== 32'h0 || o.rspCycles != 1) begin errors++; $display("[TB] FAIL to_rsp got=%0b/%h/%0d exp=1/0/1", o.slverr, o.rdata, o.rspCycles); end
    do_txn(32'h0000_0C04, 1'b0, 32'h0, 4'h0, 3'h0, 3, 32'h4444_5555, 1'b0, 0, o);
    checks++; if (o.accessCycles != 4 || o.slverr !== 1'b0 || o.rdata !== 32'h4444_5555) begin errors++; $display("[TB] FAIL to_limit_ready got=%0d/%0b/%h exp=4/0/44445555", o.accessCycles, o.slverr, o.rdata); end
  endtask
`else
  task automatic test_long_wait();
    obs_t o;
    do_txn(32'h0000_0C00, 1'b0, 32'h0, 4'h0, 3'h0, 20, 32'h8888_9999, 1'b0, 0, o);
    checks++; if (o.accessCycles != 21 || o.stable !== 1'b1) begin errors++; $display("[TB] FAIL long_wait got=cyc%0d stable%0b exp=cyc21 stable1", o.accessCycles, o.stable); end
    checks++; if (o.slverr !== 1'b0 || o.rdata !== 32'h8888_9999) begin errors++; $display("[TB] FAIL long_wait_rsp got=%0b/%h exp=0/88889999", o.slverr, o.rdata); end
  endtask
`endif

  // Random transfers against a transaction-level model: the APB phase shows
  // the request payload (strobes zero for reads), lasts waits+1 ACCESS cycles,
  // and the response carries prdata for reads, zero for writes.
  task automatic test_random();
    obs_t o;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic [SW-1:0] strb;
    logic [2:0]    prot;
    logic          wr;
    logic          serr;
    int            waits;
    int            bp;
    for (int n = 0; n < 25; n++) begin
      addr = $urandom; wdata = $urandom; rdata = $urandom;
      strb = SW'($urandom); prot = 3'($urandom);
      wr = 1'($urandom); serr = 1'($urandom);
      waits = int'($urandom_range(0, 3)); bp = int'($urandom_range(0, 2));
      do_txn(addr, wr, wdata, strb, prot, waits, rdata, serr, bp, o);
      checks++; if (o.hung !== 1'b0) begin errors++; $display("[TB] FAIL rnd%0d_hung got=1 exp=0", n); end
      checks++; if (o.paddr !== addr || o.pwrite !== wr || o.pprot !== prot) begin errors++; $display("[TB] FAIL rnd%0d_apb_ctrl got=%h/%0b/%0h exp=%h/%0b/%0h", n, o.paddr, o.pwrite, o.pprot, addr, wr, prot); end
      checks++; if (o.pwdata !== wdata || o.pstrb !== (wr ? strb : '0)) begin errors++; $display("[TB] FAIL rnd%0d_apb_data got=%h/%h exp=%h/%h", n, o.pwdata, o.pstrb, wdata, wr ? strb : '0); end
      checks++; if (o.accessCycles != waits + 1 || o.stable !== 1'b1) begin errors++; $display("[TB] FAIL rnd%0d_access got=cyc%0d stable%0b exp=cyc%0d stable1", n, o.accessCycles, o.stable, waits + 1); end
      checks++; if (o.rspCycles != bp + 1 || o.rspStable !== 1'b1) begin errors++; $display("[TB] FAIL rnd%0d_rsp_hold got=cyc%0d stable%0b exp=cyc%0d stable1", n, o.rspCycles, o.rspStable, bp + 1); end
      checks++; if (o.rdata !== (wr ? '0 : rdata) || o.slverr !== serr) begin errors++; $display("[TB] FAIL rnd%0d_rsp got=%h/%0b exp=%h/%0b", n, o.rdata, o.slverr, wr ? '0 : rdata, serr); end
      checks++; if (o.busyReady !== 1'b0 || o.readyAfter !== 1'b1 || o.holdAddr !== addr) begin errors++; $display("[TB] FAIL rnd%0d_ready got=busy%0b after%0b hold%h exp=busy0 after1 hold%h", n, o.busyReady, o.readyAfter, o.holdAddr, addr); end
    end
  endtask

  initial begin
    $display("[TB] apb_initiator bench start");
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_error_backpressure();
    test_back_to_back();
    test_reset_mid_access();
`ifdef APB_INITIATOR_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
